elegant_storage_bank: RTL and testbench

Parametrised multi-entry successor to the single 8-bit storage register. It provides one write port, one registered read port, per-entry valid tracking, a synchronous bulk-invalidate, and an occupancy count with a full flag. It sits between producer logic and consumer logic as a small addressed scratch store.

---
 rtl/elegant_storage_bank.sv | 97 +++++++++
 tb/tb_elegant_storage_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/elegant_storage_bank.sv
// rtl/elegant_storage_bank.sv - addressed scratch store with per-entry valid bits, bulk clear and occupancy count
module elegant_storage_bank #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH       = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    localparam int                   ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_hit,
    output logic                  read_done,
    output logic [ADDR_WIDTH:0]   valid_count,
    output logic                  full
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;

    logic                  wr_ok;
    logic                  rd_ok;
    logic                  wr_new;
    logic [DATA_WIDTH-1:0] rd_data_nxt;
    logic                  rd_hit_nxt;
    logic [ADDR_WIDTH:0]   count_nxt;

    always_comb begin
        wr_ok       = write_enable && ({1'b0, write_addr} < DEPTH_W);
        rd_ok       = {1'b0, read_addr} < DEPTH_W;
        wr_new      = 1'b0;
        rd_data_nxt = RESET_VALUE;
        rd_hit_nxt  = 1'b0;

        if (wr_ok) begin
            wr_new = !valid[write_addr];
        end

        // Reads observe the post-edge state, so a same-address write is forwarded.
        if (rd_ok) begin
            if (wr_ok && (write_addr == read_addr)) begin
                rd_data_nxt = data_in;
                rd_hit_nxt  = 1'b1;
            end else begin
                rd_data_nxt = mem[read_addr];
                rd_hit_nxt  = valid[read_addr] && !clear;
            end
        end

        if (clear) begin
            count_nxt = wr_ok ? COUNT_ONE : '0;
        end else if (wr_new) begin
            count_nxt = valid_count + COUNT_ONE;
        end else begin
            count_nxt = valid_count;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VALUE;
            end
            valid       <= '0;
            data_out    <= RESET_VALUE;
            read_hit    <= 1'b0;
            read_done   <= 1'b0;
            valid_count <= '0;
        end else begin
            // Later bit assignment wins, so a write survives a same-cycle clear.
            if (clear) begin
                valid <= '0;
            end
            if (wr_ok) begin
                mem[write_addr]   <= data_in;
                valid[write_addr] <= 1'b1;
            end
            read_done <= read_enable;
            if (read_enable) begin
                data_out <= rd_data_nxt;
                read_hit <= rd_hit_nxt;
            end
            valid_count <= count_nxt;
        end
    end

    assign full = (valid_count == DEPTH_W);

endmodule

// File: tb/tb_elegant_storage_bank.sv
// tb/tb_elegant_storage_bank.sv - scoreboard bench for elegant_storage_bank
module tb_elegant_storage_bank;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [DW-1:0] RV = 8'h00;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          write_enable = 1'b0;
    logic [AW-1:0] write_addr = '0;
    logic [DW-1:0] data_in = '0;
    logic          read_enable = 1'b0;
    logic [AW-1:0] read_addr = '0;
    logic          clear = 1'b0;
    logic [DW-1:0] data_out;
    logic          read_hit;
    logic          read_done;
    logic [AW:0]   valid_count;
    logic          full;

    always #5 clk = ~clk;

    elegant_storage_bank #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RESET_VALUE(RV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .write_enable(write_enable),
        .write_addr  (write_addr),
        .data_in     (data_in),
        .read_enable (read_enable),
        .read_addr   (read_addr),
        .clear       (clear),
        .data_out    (data_out),
        .read_hit    (read_hit),
        .read_done   (read_done),
        .valid_count (valid_count),
        .full        (full)
    );

    typedef struct packed {
        logic          done;
        logic [DW-1:0] data;
        logic          hit;
        logic [AW:0]   count;
        logic          full;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    bit   checking = 1'b0;

    logic [DW-1:0] m_data [DEPTH];
    bit            m_valid [DEPTH];
    logic [DW-1:0] m_out;
    bit            m_hit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i]  = RV;
            m_valid[i] = 1'b0;
        end
        m_out = RV;
        m_hit = 1'b0;
    endtask

    // One clock of stimulus; the model's view of the outputs after that edge is queued.
    task automatic cycle(input bit we, input int wa, input logic [DW-1:0] di,
                         input bit re, input int ra, input bit clr);
        exp_t e;
        int   cnt;
        @(negedge clk);
        write_enable = we;
        write_addr   = wa[AW-1:0];
        data_in      = di;
        read_enable  = re;
        read_addr    = ra[AW-1:0];
        clear        = clr;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        end
        if (we && wa < DEPTH) begin
            m_data[wa]  = di;
            m_valid[wa] = 1'b1;
        end
        if (re) begin
            if (ra < DEPTH) begin
                m_out = m_data[ra];
                m_hit = m_valid[ra];
            end else begin
                m_out = RV;
                m_hit = 1'b0;
            end
        end
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) cnt += int'(m_valid[i]);
        e.done  = re;
        e.data  = m_out;
        e.hit   = m_hit;
        e.count = cnt[AW:0];
        e.full  = (cnt == DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cycle(1'b0, 0, '0, 1'b0, 0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'(RV));
        check({tag, "_read_hit"}, 32'(read_hit), 32'd0);
        check({tag, "_read_done"}, 32'(read_done), 32'd0);
        check({tag, "_valid_count"}, 32'(valid_count), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (checking) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("read_done", 32'(read_done), 32'(mon_e.done));
                check("data_out", 32'(data_out), 32'(mon_e.data));
                check("read_hit", 32'(read_hit), 32'(mon_e.hit));
                check("valid_count", 32'(valid_count), 32'(mon_e.count));
                check("full", 32'(full), 32'(mon_e.full));
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #1;
        reset_n  = 1'b1;
        checking = 1'b1;

        // Basic write then read, then read_done must drop.
        cycle(1'b1, 3, 8'h55, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, '0, 1'b1, 3, 1'b0);
        idle();

        // Same-cycle overwrite and read of the same address.
        cycle(1'b1, 3, 8'hAA, 1'b1, 3, 1'b0);
        idle();

        // Fill, read, overwrite while full.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, i, 8'(8'h10 + i), 1'b0, 0, 1'b0);
        cycle(1'b0, 0, '0, 1'b1, 6, 1'b0);
        cycle(1'b1, 6, 8'h66, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, '0, 1'b1, 6, 1'b0);

        // Clear with a simultaneous write.
        cycle(1'b1, 5, 8'hFF, 1'b0, 0, 1'b1);
        cycle(1'b0, 0, '0, 1'b1, 5, 1'b0);
        cycle(1'b0, 0, '0, 1'b1, 2, 1'b0);

        // Bring occupancy to 4, then reset between edges.
        cycle(1'b1, 0, 8'h20, 1'b0, 0, 1'b0);
        cycle(1'b1, 1, 8'h21, 1'b0, 0, 1'b0);
        cycle(1'b1, 2, 8'h22, 1'b1, 0, 1'b0);
        @(negedge clk);
        #2;
        checking     = 1'b0;
        reset_n      = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear        = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #2;
        reset_n  = 1'b1;
        checking = 1'b1;
        cycle(1'b0, 0, '0, 1'b1, 3, 1'b0);
        cycle(1'b0, 0, '0, 1'b1, 0, 1'b0);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                  ($urandom_range(0, 15) == 0));
        end
        idle();

        @(posedge clk);
        #2;
        checking = 1'b0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
